// File: rtl/icache_axi_rd_bridge.sv
// icache_axi_rd_bridge: single-outstanding AXI4 read master for I-cache refills.
// Issues one 4-byte read per request and returns the selected 32-bit lane with a
// one-cycle completion pulse. A watchdog and error flag keep fetch from hanging.
module icache_axi_rd_bridge #(
  parameter logic [3:0]  AXI_ID  = 4'h0,
  parameter int unsigned TIMEOUT = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cache_read_ena,
  input  logic [63:0] cache_addr,
  output logic [31:0] cache_or_data,
  output logic        cache_in_ok,
  output logic        bus_err,
  output logic        arvalid,
  input  logic        arready,
  output logic [63:0] araddr,
  output logic [3:0]  arid,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  input  logic        rvalid,
  output logic        rready,
  input  logic [63:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic [3:0]  rid
);

  // A zero TIMEOUT still needs a legal one-bit counter even though it never runs.
  localparam int unsigned WD_W      = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam int unsigned WD_LAST_I = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_LAST_I[WD_W-1:0];
  localparam logic [WD_W-1:0] WD_MAX  = TIMEOUT[WD_W-1:0];

  typedef enum logic [3:0] {
    IDLE   = 4'b0001,
    AR_REQ = 4'b0010,
    R_WAIT = 4'b0100,
    DONE   = 4'b1000
  } state_t;

  state_t            state;
  logic [63:0]       req_addr;
  logic [WD_W-1:0]   wdog;
  logic              cooldown;
  logic              beat_ok;
  logic              wd_expire;
  logic              unused_inputs;

  // Watchdog counter advances by one and sticks at TIMEOUT instead of wrapping.
  function automatic logic [WD_W-1:0] wdog_sat_inc(input logic [WD_W-1:0] v);
    if (v >= WD_MAX) return v;
    return v + WD_W'(1);
  endfunction

  // Single-beat INCR reads of one 32-bit word; the address is the latched copy.
  assign arid    = AXI_ID;
  assign arlen   = 8'd0;
  assign arsize  = 3'b010;
  assign arburst = 2'b01;
  assign araddr  = req_addr;

  assign beat_ok   = rvalid && (rid == AXI_ID);
  assign wd_expire = (TIMEOUT != 0) && (wdog == WD_LAST);

  // rlast is meaningless for single-beat bursts; the low address bits are forced to zero.
  assign unused_inputs = ^{rlast, cache_addr[1:0]};

  // Request/response FSM with all outputs registered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      req_addr      <= '0;
      arvalid       <= 1'b0;
      rready        <= 1'b0;
      cache_in_ok   <= 1'b0;
      cache_or_data <= '0;
      bus_err       <= 1'b0;
      wdog          <= '0;
      cooldown      <= 1'b0;
    end else begin
      cache_in_ok <= 1'b0;
      case (state)
        IDLE: begin
          rready   <= 1'b1;
          cooldown <= 1'b0;
          if (cache_read_ena && !cooldown) begin
            req_addr <= {cache_addr[63:2], 2'b00};
            bus_err  <= 1'b0;
            arvalid  <= 1'b1;
            rready   <= 1'b0;
            state    <= AR_REQ;
          end
        end
        AR_REQ: begin
          if (arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            wdog    <= '0;
            state   <= R_WAIT;
          end
        end
        R_WAIT: begin
          // A real beat takes priority over a coincident watchdog expiry.
          if (beat_ok) begin
            cache_or_data <= req_addr[2] ? rdata[63:32] : rdata[31:0];
            bus_err       <= rresp[1];
            cache_in_ok   <= 1'b1;
            state         <= DONE;
          end else if (wd_expire) begin
            cache_or_data <= '0;
            bus_err       <= 1'b1;
            cache_in_ok   <= 1'b1;
            state         <= DONE;
          end else if (TIMEOUT != 0) begin
            wdog <= wdog_sat_inc(wdog);
          end
        end
        DONE: begin
          // Requester drops its level in the completion cycle; skip one IDLE sample.
          cooldown <= 1'b1;
          state    <= IDLE;
        end
        default: begin
          arvalid <= 1'b0;
          rready  <= 1'b1;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_icache_axi_rd_bridge.sv
// Self-checking bench for icache_axi_rd_bridge with a completion scoreboard.
module tb_icache_axi_rd_bridge;

  localparam logic [3:0] ID_TB = 4'h3;

  logic        clk = 1'b0;
  logic        rst;
  logic        cache_read_ena;
  logic [63:0] cache_addr;
  logic [31:0] cache_or_data;
  logic        cache_in_ok;
  logic        bus_err;
  logic        arvalid;
  logic        arready;
  logic [63:0] araddr;
  logic [3:0]  arid;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        rvalid;
  logic        rready;
  logic [63:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic [3:0]  rid;

  int n_cmp = 0;
  int n_bad = 0;

  // Expected completions: {word, bus_err}
  logic [32:0] sb_q[$];
  logic [32:0] exp_e;

  icache_axi_rd_bridge #(.AXI_ID(ID_TB), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .cache_read_ena(cache_read_ena), .cache_addr(cache_addr),
    .cache_or_data(cache_or_data), .cache_in_ok(cache_in_ok), .bus_err(bus_err),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid),
    .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
    .rlast(rlast), .rid(rid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Every completion pulse must match the oldest expected result.
  always @(negedge clk) begin
    if (rst && cache_in_ok) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_ok", cache_in_ok, 0);
      end else begin
        exp_e = sb_q.pop_front();
        chk("rd_data", cache_or_data, exp_e[32:1]);
        chk("rd_err", bus_err, exp_e[0]);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge while the bridge is able to sample; returns one cycle after DONE.
  task automatic do_read(input logic [63:0] addr, input int ar_stall, input int r_delay,
                         input logic [63:0] data, input logic [1:0] resp,
                         input bit stray, input bit hold);
    logic [63:0] exp_addr;
    logic [31:0] exp_word;
    exp_addr = {addr[63:2], 2'b00};
    exp_word = addr[2] ? data[63:32] : data[31:0];
    sb_q.push_back({exp_word, resp[1]});
    cache_read_ena = 1'b1;
    cache_addr     = addr;
    arready        = 1'b0;
    @(negedge clk);
    cache_addr = ~addr;
    chk("bus_err_clr", bus_err, 0);
    chk("rready_ar", rready, 0);
    for (int i = 0; i < ar_stall; i++) begin
      chk("arvalid_stall", arvalid, 1);
      chk("araddr_stall", araddr, exp_addr);
      @(negedge clk);
    end
    chk("arvalid", arvalid, 1);
    chk("araddr", araddr, exp_addr);
    arready = 1'b1;
    @(negedge clk);
    arready = 1'b0;
    chk("arvalid_drop", arvalid, 0);
    chk("rready_rw", rready, 1);
    if (stray) begin
      rvalid = 1'b1; rid = ~ID_TB; rdata = ~data; rresp = 2'b10;
      @(negedge clk);
      rvalid = 1'b0;
      chk("stray_no_ok", cache_in_ok, 0);
    end
    repeat (r_delay) @(negedge clk);
    rvalid = 1'b1; rid = ID_TB; rdata = data; rresp = resp;
    @(negedge clk);
    rvalid = 1'b0; rresp = 2'b00;
    if (!hold) cache_read_ena = 1'b0;
    chk("in_ok", cache_in_ok, 1);
    @(negedge clk);
    chk("in_ok_pulse", cache_in_ok, 0);
    chk("data_hold", cache_or_data, exp_word);
    chk("err_hold", bus_err, resp[1]);
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; cache_read_ena = 1'b0; cache_addr = '0; arready = 1'b0;
    rvalid = 1'b0; rdata = '0; rresp = 2'b00; rlast = 1'b1; rid = ID_TB;
    idle(2);
    chk("rst_arvalid", arvalid, 0);
    chk("rst_araddr", araddr, 0);
    chk("rst_rready", rready, 0);
    chk("rst_in_ok", cache_in_ok, 0);
    chk("rst_data", cache_or_data, 0);
    chk("rst_err", bus_err, 0);
    chk("arid", arid, ID_TB);
    chk("arlen", arlen, 0);
    chk("arsize", arsize, 3'b010);
    chk("arburst", arburst, 2'b01);
    rst = 1'b1;
    idle(2);

    // Upper lane, minimum latency
    do_read(64'h8000_0004, 0, 0, 64'h1111_2222_3333_4444, 2'b00, 1'b0, 1'b0);
    idle(1);
    // Lower lane with AR and R stalls
    do_read(64'h8000_0000, 3, 5, 64'h1111_2222_3333_4444, 2'b00, 1'b0, 1'b0);
    idle(1);
    // SLVERR then a clean read clearing the flag
    do_read(64'h8000_0008, 0, 1, 64'hdead_beef_cafe_f00d, 2'b10, 1'b0, 1'b0);
    idle(1);
    do_read(64'h8000_000c, 0, 0, 64'h0123_4567_89ab_cdef, 2'b00, 1'b0, 1'b0);
    idle(1);
    // Beat arrives on the same cycle the watchdog expires
    do_read(64'h8000_0010, 0, 7, 64'h5555_6666_7777_8888, 2'b00, 1'b0, 1'b0);
    idle(1);

    // Watchdog expiry with no beat, then a late beat absorbed in IDLE
    sb_q.push_back({32'h0, 1'b1});
    cache_read_ena = 1'b1; cache_addr = 64'h8000_0100; arready = 1'b1;
    @(negedge clk);
    chk("wd_arvalid", arvalid, 1);
    @(negedge clk);
    arready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("wd_wait", cache_in_ok, 0);
      @(negedge clk);
    end
    cache_read_ena = 1'b0;
    chk("wd_ok", cache_in_ok, 1);
    idle(3);
    chk("late_rready", rready, 1);
    rvalid = 1'b1; rid = ID_TB; rdata = 64'h9999_aaaa_bbbb_cccc;
    @(negedge clk);
    rvalid = 1'b0;
    chk("late_no_ok", cache_in_ok, 0);
    @(negedge clk);
    chk("late_no_ok2", cache_in_ok, 0);
    chk("late_idle", arvalid, 0);
    idle(1);

    // Stray ID dropped; request held through DONE honours the cooldown
    do_read(64'h8000_0014, 0, 1, 64'hfeed_face_0bad_c0de, 2'b00, 1'b1, 1'b1);
    chk("cool_d1", arvalid, 0);
    @(negedge clk);
    chk("cool_d2", arvalid, 0);
    do_read(64'h8000_0018, 1, 0, 64'h1357_9bdf_2468_ace0, 2'b11, 1'b0, 1'b0);
    idle(1);

    // Asynchronous reset while waiting for R
    cache_read_ena = 1'b1; cache_addr = 64'h8000_0200; arready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    arready = 1'b0;
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("arst_arvalid", arvalid, 0);
    chk("arst_araddr", araddr, 0);
    chk("arst_rready", rready, 0);
    chk("arst_in_ok", cache_in_ok, 0);
    chk("arst_data", cache_or_data, 0);
    chk("arst_err", bus_err, 0);
    @(negedge clk);
    cache_read_ena = 1'b0;
    rst = 1'b1;
    idle(1);
    do_read(64'h8000_0204, 0, 0, 64'h4242_4242_0000_0001, 2'b00, 1'b0, 1'b0);
    idle(2);

    chk("sb_empty", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
